// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, converter state type and helpers for the countdown display.
package seg_scan_ctrl_pkg;

    // Nibble value that the decoder renders as an unlit digit
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    // All cathodes off (active-low)
    localparam logic [6:0] SEG_OFF      = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Largest value representable on n decimal digits: 10^n - 1
    function automatic int unsigned max_val(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// Values above 10^NUM_DIGITS-1 saturate to all nines and raise over.
// done pulses for the single COMMIT cycle while bcd holds the final result.
module bin2bcd_seq
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned VAL_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [VAL_W-1:0]        value_bin,
    output logic                    busy,
    output logic                    done,
    output logic                    over,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned SW = BW + VAL_W;
    localparam int unsigned CW = $clog2(VAL_W + 1);
    localparam logic [VAL_W-1:0] MAXV = VAL_W'(max_val(NUM_DIGITS));

    conv_state_t     state, state_next;
    logic [SW-1:0]   sreg, sreg_adj;
    logic [CW-1:0]   cnt;
    logic [VAL_W-1:0] sat_val;

    // Converter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: capture on load, VAL_W shift iterations, one commit cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(VAL_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == COMMIT);
    end

    // Saturate the captured value and apply the add-3 step to every BCD nibble
    always_comb begin
        sat_val  = (value_bin > MAXV) ? MAXV : value_bin;
        sreg_adj = sreg;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sreg[VAL_W+4*i +: 4] >= 4'd5) begin
                sreg_adj[VAL_W+4*i +: 4] = sreg[VAL_W+4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register, iteration counter and saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            over <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    sreg <= SW'(sat_val);
                    cnt  <= '0;
                    over <= (value_bin > MAXV);
                end
                SHIFT: begin
                    sreg <= sreg_adj << 1;
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd = sreg[SW-1:VAL_W];

endmodule

// File: rtl/seven_segment.sv
// Hex-digit to seven-segment decoder, active-low cathodes, bit order gfedcba.
// Only 0..9 are lit; every other code (including BLANK_NIBBLE) is dark.
module seven_segment
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup from digit code to cathode pattern
    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode countdown display: binary load -> BCD shadow ->
// scanned digits through one shared seven_segment decoder.
// Optional macro LEADING_ZERO_BLANK_EN: store leading zero digits (except
// digit 0) as blank so "07" is shown as " 7".
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS  = 2,
    parameter  int unsigned REFRESH_DIV = 50000,
    parameter  int unsigned DEAD_CYCLES = 4,
    localparam int unsigned VAL_W       = (NUM_DIGITS == 2) ? 7 : 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value_bin,
    input  logic                  blank,
    output logic                  busy,
    output logic                  over,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg
);

    localparam int unsigned BW = 4 * NUM_DIGITS;
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [BW-1:0] SHADOW_RST = {{(NUM_DIGITS-1){BLANK_NIBBLE}}, 4'h0};
`else
    localparam logic [BW-1:0] SHADOW_RST = '0;
`endif

    logic                  conv_done;
    logic [BW-1:0]         conv_bcd;
    logic [BW-1:0]         commit_val;
    logic [BW-1:0]         shadow;
    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [NUM_DIGITS-1:0] an_next;
    logic [3:0]            dec_in;
    logic [6:0]            dec_seg;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .VAL_W      (VAL_W)
    ) u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value_bin (value_bin),
        .busy      (busy),
        .done      (conv_done),
        .over      (over),
        .bcd       (conv_bcd)
    );

    // Value written to the shadow at commit (optionally with leading zeros blanked)
    always_comb begin
        commit_val = conv_bcd;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic        lead;
            int unsigned i;
            lead = 1'b1;
            for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
                i = NUM_DIGITS - 1 - k;
                if (lead && conv_bcd[4*i +: 4] == 4'd0) begin
                    commit_val[4*i +: 4] = BLANK_NIBBLE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    // Display shadow: replaced whole in one cycle so no partial value is visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shadow <= SHADOW_RST;
        else if (conv_done) shadow <= commit_val;
    end

    // Slot prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Anode select and decoder input for the current slot position
    always_comb begin
        an_next = '1;
        dec_in  = BLANK_NIBBLE;
        if (!blank && presc >= PW'(DEAD_CYCLES)) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (IW'(i) == idx) begin
                    an_next[i] = 1'b0;
                    dec_in     = shadow[4*i +: 4];
                end
            end
        end
    end

    seven_segment u_dec (
        .digit (dec_in),
        .seg   (dec_seg)
    );

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n <= '1;
            seg  <= SEG_OFF;
        end else begin
            an_n <= an_next;
            seg  <= dec_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed + randomized bench for seg_scan_ctrl (2 digits, 8-cycle slots,
// 2 dead cycles). The model predicts the display from the decimal value,
// the edge count since reset and the converter latency.
module tb_seg_scan_ctrl;

    localparam int unsigned N    = 2;
    localparam int unsigned R    = 8;
    localparam int unsigned D    = 2;
    localparam int unsigned VW   = 7;
    localparam int unsigned MAXV = 99;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [VW-1:0] value_bin = '0;
    logic          blank = 1'b0;
    logic          busy, over;
    logic [N-1:0]  an_n;
    logic [6:0]    seg;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value_bin (value_bin),
        .blank     (blank),
        .busy      (busy),
        .over      (over),
        .an_n      (an_n),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned edge_cnt   = 0;
    int unsigned free_edge  = 0;
    int unsigned commit_e   = 0;
    int unsigned pend_val   = 0;
    int unsigned shadow_val = 0;
    bit          pending    = 1'b0;
    bit          exp_over   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    bit          lzb = 1'b1;
`else
    bit          lzb = 1'b0;
`endif

    function automatic logic [6:0] seg_of(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output with the model
    task automatic step();
        int unsigned e, p, ix, pw;
        logic [N-1:0] ea;
        logic [6:0]   es;
        e  = edge_cnt + 1;
        p  = (e - 1) % R;
        ix = ((e - 1) / R) % N;
        ea = '1;
        es = 7'b1111111;
        if (!blank && p >= D) begin
            pw = 1;
            for (int unsigned j = 0; j < ix; j++) pw = pw * 10;
            ea = ~(N'(1) << ix);
            if (lzb && ix > 0 && shadow_val < pw) es = 7'b1111111;
            else                                  es = seg_of((shadow_val / pw) % 10);
        end
        if (load && e >= free_edge) begin
            pending   = 1'b1;
            commit_e  = e + VW + 1;
            free_edge = e + VW + 2;
            pend_val  = (value_bin > MAXV) ? MAXV : int'(value_bin);
            exp_over  = (value_bin > MAXV);
        end
        if (pending && e == commit_e) begin
            shadow_val = pend_val;
            pending    = 1'b0;
        end
        @(posedge clk);
        #1;
        edge_cnt = e;
        chk("an_n", 32'(an_n), 32'(ea));
        chk("seg",  32'(seg),  32'(es));
        chk("busy", 32'(busy), 32'(pending));
        chk("over", 32'(over), 32'(exp_over));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int unsigned v);
        value_bin = VW'(v);
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_an_n", 32'(an_n), 32'(2'b11));
        chk("rst_seg",  32'(seg),  32'(7'b1111111));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_over", 32'(over), 32'd0);
    endtask

    task automatic model_reset();
        edge_cnt   = 0;
        free_edge  = 0;
        pending    = 1'b0;
        exp_over   = 1'b0;
        shadow_val = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned v, guard;

        // Reset state
        #12;
        check_reset_vals();
        release_reset();
        model_reset();

        // Idle scan of "00" / " 0"
        run(32);

        // 42: busy for 8 cycles, then "42"
        do_load(42);
        run(30);

        // Saturation to 99, then cleared by a small value
        do_load(127);
        run(30);
        do_load(5);
        run(30);

        // Load while busy is ignored
        do_load(37);
        run(2);
        do_load(12);
        run(30);

        // Reset in the middle of a conversion
        do_load(88);
        run(4);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        release_reset();
        run(32);

        // Blank for 20 cycles mid-scan, then resume
        do_load(63);
        run(14);
        blank = 1'b1;
        run(20);
        blank = 1'b0;
        run(24);

        // Single-digit value (leading-zero behaviour depends on the macro)
        do_load(7);
        run(30);
        do_load(0);
        run(30);

        // Randomized loads, blanks and overlapping loads
        for (int k = 0; k < 12; k++) begin
            guard = 0;
            while (pending && guard < 20) begin
                step();
                guard++;
            end
            v = $urandom_range(0, 127);
            do_load(v);
            if ($urandom_range(0, 1) == 1) begin
                run($urandom_range(0, 6));
                do_load($urandom_range(0, 127));
            end
            blank = ($urandom_range(0, 3) == 0);
            run($urandom_range(5, 12));
            blank = 1'b0;
            run(20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
